switch_fabric_ctrl: RTL and testbench

Configuration controller for a bank of NUM_SW unidirectional switch cells in the reconfigurable emulator fabric. Each cell is driven by one enable bit. A host writes the desired connection pattern into a shadow register, then issues apply. The controller commits the pattern using break-before-make sequencing, so two switches never drive the same net at once. It sits between the host config port and the enable inputs of the switch cells.

---
 rtl/fabric_ctrl_pkg.sv | 15 +
 rtl/sw_settle_timer.sv | 44 ++++
 rtl/switch_fabric_ctrl.sv | 121 ++++++++++++
 tb/tb_switch_fabric_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/fabric_ctrl_pkg.sv
// Shared definitions for fabric configuration sequencers: state encoding and timing default.
`default_nettype none

package fabric_ctrl_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BREAK = 1'b1
   } fab_state_e;

   localparam int DEF_SETTLE_CYC = 4;

endpackage

`default_nettype wire

// File: rtl/sw_settle_timer.sv
// Down-counter holding a fabric pattern for a fixed number of cycles; load, decrement, zero flag.
`default_nettype none

module sw_settle_timer
   import fabric_ctrl_pkg::*;
#(
   parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic dec_i,
   input  logic clr_i,
   output logic zero_o
);

   localparam int CNT_W = $clog2(SETTLE_CYC + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = CNT_W'(SETTLE_CYC - 1);
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/switch_fabric_ctrl.sv
// Shadowed switch-enable controller committing new patterns with break-before-make sequencing.
`default_nettype none

module switch_fabric_ctrl
   import fabric_ctrl_pkg::*;
#(
   parameter int NUM_SW     = 16,
   parameter int ADDR_W     = 4,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic              wr_data,
   input  logic              clr_shadow,
   input  logic              apply,
   input  logic              kill,
   output logic [NUM_SW-1:0] enable,
   output logic [NUM_SW-1:0] shadow_q,
   output logic              busy,
   output logic              done
);

   fab_state_e        state_q, state_d;
   logic [NUM_SW-1:0] shadow_d;
   logic [NUM_SW-1:0] target_q, target_d;
   logic [NUM_SW-1:0] enable_q, enable_d;
   logic              done_q, done_d;
   logic              tmr_load, tmr_dec, tmr_clr, tmr_zero;

   // Out-of-range addresses match no bit, so they are dropped naturally.
   always_comb begin
      shadow_d = shadow_q;
      if (clr_shadow) begin
         shadow_d = '0;
      end
      for (int i = 0; i < NUM_SW; i++) begin
         if (wr_en && (wr_addr == ADDR_W'(i))) begin
            shadow_d[i] = wr_data;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      enable_d = enable_q;
      done_d   = 1'b0;
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;
      tmr_clr  = 1'b0;
      if (kill) begin
         enable_d = '0;
         state_d  = ST_IDLE;
         tmr_clr  = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (apply) begin
                  target_d = shadow_q;
                  if ((enable_q & ~shadow_q) == '0) begin
                     enable_d = shadow_q;
                     done_d   = 1'b1;
                  end else begin
                     enable_d = enable_q & shadow_q;
                     tmr_load = 1'b1;
                     state_d  = ST_BREAK;
                  end
               end
            end
            ST_BREAK: begin
               if (tmr_zero) begin
                  enable_d = target_q;
                  done_d   = 1'b1;
                  state_d  = ST_IDLE;
               end else begin
                  tmr_dec = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         shadow_q <= '0;
         target_q <= '0;
         enable_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         target_q <= target_d;
         enable_q <= enable_d;
         done_q   <= done_d;
      end
   end

   sw_settle_timer #(
      .SETTLE_CYC (SETTLE_CYC)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load_i (tmr_load),
      .dec_i  (tmr_dec),
      .clr_i  (tmr_clr),
      .zero_o (tmr_zero)
   );

   assign enable = enable_q;
   assign busy   = (state_q == ST_BREAK);
   assign done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_switch_fabric_ctrl.sv
// Directed bench for switch_fabric_ctrl with NUM_SW=8, SETTLE_CYC=3.
`default_nettype none

module tb_switch_fabric_ctrl;

   localparam int NUM_SW     = 8;
   localparam int ADDR_W     = 4;
   localparam int SETTLE_CYC = 3;

   logic              clk = 1'b0;
   logic              rst, wr_en, wr_data, clr_shadow, apply, kill;
   logic [ADDR_W-1:0] wr_addr;
   logic [NUM_SW-1:0] enable, shadow_q;
   logic              busy, done;

   int total = 0;
   int bad   = 0;

   switch_fabric_ctrl #(
      .NUM_SW     (NUM_SW),
      .ADDR_W     (ADDR_W),
      .SETTLE_CYC (SETTLE_CYC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .clr_shadow (clr_shadow),
      .apply      (apply),
      .kill       (kill),
      .enable     (enable),
      .shadow_q   (shadow_q),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // Inputs are set just after an edge; outputs checked 1 time unit after the next edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int addr, input logic d, input logic clr);
      wr_en = 1'b1; wr_addr = ADDR_W'(addr); wr_data = d; clr_shadow = clr;
      step();
      wr_en = 1'b0; clr_shadow = 1'b0;
   endtask

   task automatic st(input string tag, input logic [7:0] en, input logic b, input logic d);
      chk({tag, ".enable"}, 32'(enable), 32'(en));
      chk({tag, ".busy"},   32'(busy),   32'(b));
      chk({tag, ".done"},   32'(done),   32'(d));
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = 1'b0;
      clr_shadow = 1'b0; apply = 1'b0; kill = 1'b0;
      #1; step(); step();
      rst = 1'b0;
      st("reset", 8'h00, 1'b0, 1'b0);
      chk("reset.shadow", 32'(shadow_q), 32'h00);

      // direct commit, no switch turning off
      wr(0, 1'b1, 1'b0);
      wr(2, 1'b1, 1'b0);
      chk("wr.shadow", 32'(shadow_q), 32'h05);
      apply = 1'b1; step(); apply = 1'b0;
      st("direct.t1", 8'h05, 1'b0, 1'b1);
      step();
      st("direct.t2", 8'h05, 1'b0, 1'b0);

      // break-before-make 0x05 -> 0x06, second apply during BREAK ignored
      wr(1, 1'b1, 1'b1);
      wr(2, 1'b1, 1'b0);
      chk("bbm.shadow", 32'(shadow_q), 32'h06);
      apply = 1'b1; step(); apply = 1'b0;
      st("bbm.t1", 8'h04, 1'b1, 1'b0);
      apply = 1'b1; step(); apply = 1'b0;
      st("bbm.t2", 8'h04, 1'b1, 1'b0);
      step();
      st("bbm.t3", 8'h04, 1'b1, 1'b0);
      step();
      st("bbm.t4", 8'h06, 1'b0, 1'b1);
      step();
      st("bbm.t5", 8'h06, 1'b0, 1'b0);

      // apply with same-cycle write: target uses pre-write shadow
      wr(0, 1'b1, 1'b1);
      chk("sw.shadow0", 32'(shadow_q), 32'h01);
      apply = 1'b1; wr_en = 1'b1; wr_addr = 4'd1; wr_data = 1'b1;
      step();
      apply = 1'b0; wr_en = 1'b0;
      st("sw.t1", 8'h00, 1'b1, 1'b0);
      chk("sw.shadow1", 32'(shadow_q), 32'h03);
      step(); step();
      st("sw.t3", 8'h00, 1'b1, 1'b0);
      step();
      st("sw.t4", 8'h01, 1'b0, 1'b1);

      // grow to 0x03 directly, then kill a commit toward 0x02
      apply = 1'b1; step(); apply = 1'b0;
      st("grow", 8'h03, 1'b0, 1'b1);
      wr(0, 1'b0, 1'b0);
      chk("kill.shadow0", 32'(shadow_q), 32'h02);
      apply = 1'b1; step(); apply = 1'b0;
      st("kill.t1", 8'h02, 1'b1, 1'b0);
      step();
      kill = 1'b1; step(); kill = 1'b0;
      st("kill.t3", 8'h00, 1'b0, 1'b0);
      chk("kill.shadow", 32'(shadow_q), 32'h02);
      step(); step();
      st("kill.t5", 8'h00, 1'b0, 1'b0);
      apply = 1'b1; step(); apply = 1'b0;
      st("kill.recommit", 8'h02, 1'b0, 1'b1);

      // address bounds and clear+write priority
      wr(9, 1'b1, 1'b0);
      chk("oob.shadow", 32'(shadow_q), 32'h02);
      wr(3, 1'b1, 1'b0);
      chk("set3.shadow", 32'(shadow_q), 32'h0A);
      apply = 1'b1; step(); apply = 1'b0;
      st("commit0a", 8'h0A, 1'b0, 1'b1);
      wr(3, 1'b1, 1'b1);
      chk("clrwr.shadow", 32'(shadow_q), 32'h08);

      // reset in the middle of BREAK
      apply = 1'b1; step(); apply = 1'b0;
      st("rstb.t1", 8'h08, 1'b1, 1'b0);
      rst = 1'b1; step(); rst = 1'b0;
      st("rstb.t2", 8'h00, 1'b0, 1'b0);
      chk("rstb.shadow", 32'(shadow_q), 32'h00);
      step(); step(); step();
      st("rstb.nomake", 8'h00, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
